// File: rtl/count_log_pkg.sv
// count_log_pkg: event type codes and entry field packing for count_event_logger
package count_log_pkg;
    localparam logic [1:0] EV_MATCH = 2'b01;
    localparam logic [1:0] EV_WRAP  = 2'b10;
    localparam logic [1:0] EV_BOTH  = 2'b11;
    function automatic int entry_w(int ts_w);
        return 2 + 4 + ts_w;
    endfunction
    function automatic logic [5:0] pack_tv(logic [1:0] t, logic [3:0] v);
        return {v, t};
    endfunction
    function automatic logic [1:0] entry_type(logic [5:0] f);
        return f[1:0];
    endfunction
    function automatic logic [3:0] entry_value(logic [5:0] f);
        return f[5:2];
    endfunction
endpackage

// File: rtl/count_log_fifo.sv
// count_log_fifo: in-order sync FIFO; ports clk, reset, push/din, pop/dout, full, empty (push+pop allowed when full)
module count_log_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign dout  = mem[rp];
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
endmodule

// File: rtl/count_event_logger.sv
// count_event_logger: detects MATCH/WRAP_A on sampled a_cnt/b_cnt, timestamps and queues events; ports clk, reset, in_valid/a_cnt/b_cnt in, ev_* valid/ready out, overflow/drop_cnt/clr_ovf
module count_event_logger
    import count_log_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TS_W   = 8,
    parameter int DROP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [3:0]        a_cnt,
    input  logic [3:0]        b_cnt,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [1:0]        ev_type,
    output logic [3:0]        ev_value,
    output logic [TS_W-1:0]   ev_ts,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int EW = entry_w(TS_W);
    logic [TS_W-1:0] ts;
    logic [3:0]      prev_a;
    logic            prev_eq, have_prev;
    logic            is_match, is_wrap, ev, pop, push, drop, full, empty;
    logic [1:0]      typ;
    logic [EW-1:0]   din, dout;
    assign is_match = in_valid && a_cnt == b_cnt && !prev_eq;
    assign is_wrap  = in_valid && have_prev && prev_a == 4'hF && a_cnt == 4'h0;
    assign ev       = is_match || is_wrap;
    assign typ      = is_match && is_wrap ? EV_BOTH : is_wrap ? EV_WRAP : EV_MATCH;
    assign din      = {ts, pack_tv(typ, a_cnt)};
    assign ev_valid = !empty;
    assign pop      = ev_valid && ev_ready;
    assign push     = ev && (!full || pop);
    assign drop     = ev && full && !pop;
    assign ev_type  = empty ? '0 : entry_type(dout[5:0]);
    assign ev_value = empty ? '0 : entry_value(dout[5:0]);
    assign ev_ts    = empty ? '0 : dout[EW-1:6];
    count_log_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            ts        <= '0;
            prev_eq   <= 1'b0;
            prev_a    <= '0;
            have_prev <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (in_valid) begin
                prev_eq   <= a_cnt == b_cnt;
                prev_a    <= a_cnt;
                have_prev <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= clr_ovf ? DROP_W'(1) : drop_cnt + DROP_W'(!(&drop_cnt));
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_count_event_logger.sv
// tb_count_event_logger: scoreboard bench for count_event_logger with directed vectors
module tb_count_event_logger;
    logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, ev_ready = 1'b0, clr_ovf = 1'b0;
    logic [3:0] a_cnt = '0, b_cnt = '0;
    logic       ev_valid, overflow;
    logic [1:0] ev_type;
    logic [3:0] ev_value, drop_cnt;
    logic [7:0] ev_ts;
    logic [7:0] tb_ts = '0;
    logic [13:0] exp_q [$];
    int n_chk = 0, n_fail = 0;

    count_event_logger #(.DEPTH(4), .TS_W(8), .DROP_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_type  (ev_type),
        .ev_value (ev_value),
        .ev_ts    (ev_ts),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tb_ts <= reset ? 8'd0 : tb_ts + 8'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset && ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %0h expected none", {ev_type, ev_value, ev_ts});
                end else
                    check("event", 32'({ev_type, ev_value, ev_ts}), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic sample(input logic [3:0] a, input logic [3:0] b, input bit e, input logic [1:0] t);
        in_valid = 1'b1;
        a_cnt = a;
        b_cnt = b;
        if (e) exp_q.push_back({t, a, tb_ts});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_type", ev_type, 0);
        check("rst_ev_value", ev_value, 0);
        check("rst_ev_ts", ev_ts, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ev_ready = 1'b1;
        exp_q.push_back({2'b01, 4'd3, 8'd5});
        sample(4'd3, 4'd3, 0, 2'b00);
        check("match_latency_valid", ev_valid, 1);
        sample(4'd3, 4'd3, 0, 2'b00);
        check("repeat_eq_no_event", ev_valid, 0);
        sample(4'hF, 4'd1, 0, 2'b00);
        sample(4'h0, 4'd5, 1, 2'b10);
        sample(4'hF, 4'd0, 0, 2'b00);
        sample(4'h0, 4'd0, 1, 2'b11);
        repeat (2) @(posedge clk);
        #1;
        ev_ready = 1'b0;
        for (int i = 5; i <= 10; i++) begin
            sample(4'(i), 4'(i + 1), 0, 2'b00);
            sample(4'(i), 4'(i), i <= 8, 2'b01);
        end
        check("ovf_set", overflow, 1);
        check("ovf_drop_cnt", drop_cnt, 2);
        check("ovf_head_valid", ev_valid, 1);
        check("ovf_head_type_stable", ev_type, 1);
        check("ovf_head_value_stable", ev_value, 5);
        ev_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("ovf_drained", ev_valid, 0);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_drop_cnt", drop_cnt, 0);
        ev_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sample(4'(i), 4'd0, 0, 2'b00);
            sample(4'(i), 4'(i), 1, 2'b01);
        end
        sample(4'd5, 4'd0, 0, 2'b00);
        ev_ready = 1'b1;
        sample(4'd5, 4'd5, 1, 2'b01);
        ev_ready = 1'b0;
        check("full_pushpop_overflow", overflow, 0);
        check("full_pushpop_drop_cnt", drop_cnt, 0);
        ev_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("full_pushpop_drained", ev_valid, 0);
        ev_ready = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            sample(4'(i), 4'd0, 0, 2'b00);
            sample(4'(i), 4'(i), 0, 2'b00);
        end
        sample(4'd14, 4'd0, 0, 2'b00);
        sample(4'd14, 4'd14, 0, 2'b00);
        check("drop_one_cnt", drop_cnt, 1);
        sample(4'hF, 4'd0, 0, 2'b00);
        clr_ovf = 1'b1;
        sample(4'hF, 4'hF, 0, 2'b00);
        clr_ovf = 1'b0;
        check("clr_vs_drop_overflow", overflow, 1);
        check("clr_vs_drop_cnt", drop_cnt, 1);
        reset = 1'b1;
        in_valid = 1'b1;
        a_cnt = 4'd9;
        b_cnt = 4'd9;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        check("midrst_ev_valid", ev_valid, 0);
        check("midrst_drop_cnt", drop_cnt, 0);
        check("midrst_overflow", overflow, 0);
        ev_ready = 1'b1;
        exp_q.push_back({2'b01, 4'd0, 8'd0});
        sample(4'h0, 4'h0, 0, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        check("end_ev_valid", ev_valid, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
